// File: rtl/arm_mc_pkg.sv
// Shared types and encodings for the multicycle ARM controller.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_HALT
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/arm_cond_check.sv
// Combinational ARM condition evaluation against the registered NZCV flags.
module arm_cond_check
    import arm_mc_pkg::*;
(
    input  logic [3:0] i_cond,
    input  logic [3:0] i_flags,
    output logic       o_condex
);

    logic w_n, w_z, w_c, w_v, w_ge;

    assign {w_n, w_z, w_c, w_v} = i_flags;
    assign w_ge = (w_n == w_v);

    always_comb begin
        case (i_cond)
            COND_EQ: o_condex = w_z;
            COND_NE: o_condex = ~w_z;
            COND_CS: o_condex = w_c;
            COND_CC: o_condex = ~w_c;
            COND_MI: o_condex = w_n;
            COND_PL: o_condex = ~w_n;
            COND_VS: o_condex = w_v;
            COND_VC: o_condex = ~w_v;
            COND_HI: o_condex = w_c & ~w_z;
            COND_LS: o_condex = ~w_c | w_z;
            COND_GE: o_condex = w_ge;
            COND_LT: o_condex = ~w_ge;
            COND_GT: o_condex = ~w_z & w_ge;
            COND_LE: o_condex = w_z | ~w_ge;
            COND_AL: o_condex = 1'b1;
            default: o_condex = 1'b0;
        endcase
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM controller: FSM, NZCV flags, memory handshake with timeout, retire counter.
// Define ARM_MC_CMP_EN to accept CMP/TST as flag-only data-processing ops.
module arm_mc_controller
    import arm_mc_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [19:0]      Instr,
    input  logic [3:0]       ALUFlags,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       RegSrc,
    output logic [1:0]       ImmSrc,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUControl,
    output logic [1:0]       ResultSrc,
    output logic             UndefInstr,
    output logic             MemErr,
    output logic [CNT_W-1:0] Retired
);

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_t           r_state;
    logic [3:0]       r_flags;
    logic [WCW-1:0]   r_wait;
    logic             r_memerr;
    logic [CNT_W-1:0] r_retired;

    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op, w_alu_ctl, w_regsrc;
    logic       w_i, w_s, w_condex, w_legal, w_nowrite, w_arith, w_undef;
    logic       w_wait_state, w_timeout, w_unused_bits;

    assign w_cond = Instr[19:16];
    assign w_op   = Instr[15:14];
    assign w_i    = Instr[13];
    assign w_cmd  = Instr[12:9];
    assign w_s    = Instr[8];
    assign w_rd   = Instr[3:0];
    assign w_unused_bits = ^Instr[7:4];

    arm_cond_check u_cond (
        .i_cond   (w_cond),
        .i_flags  (r_flags),
        .o_condex (w_condex)
    );

    always_comb begin
        w_legal   = 1'b1;
        w_nowrite = 1'b0;
        w_arith   = 1'b0;
        w_alu_ctl = ALU_ADD;
        case (w_cmd)
            CMD_ADD: w_arith = 1'b1;
            CMD_SUB: begin w_arith = 1'b1; w_alu_ctl = ALU_SUB; end
            CMD_AND: w_alu_ctl = ALU_AND;
            CMD_ORR: w_alu_ctl = ALU_ORR;
`ifdef ARM_MC_CMP_EN
            CMD_CMP: begin w_arith = 1'b1; w_nowrite = 1'b1; w_alu_ctl = ALU_SUB; end
            CMD_TST: begin w_nowrite = 1'b1; w_alu_ctl = ALU_AND; end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    assign w_undef  = (w_op == OP_UND) || ((w_op == OP_DP) && !w_legal);
    // Stores read Rd as the second operand; branches read PC as Rn.
    assign w_regsrc = {(w_op == OP_MEM) && !w_s, (w_op == OP_BR)};

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                          (r_state == S_MEMWRITE);
    // Fires on the WAIT_MAX-th consecutive stalled cycle; a ready cycle never times out.
    assign w_timeout = (WAIT_MAX != 0) && w_wait_state && !MemReady &&
                       (r_wait == WCW'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_wait    <= '0;
            r_memerr  <= 1'b0;
            r_retired <= '0;
        end else begin
            r_wait <= (w_wait_state && !MemReady) ? r_wait + WCW'(1) : '0;
            case (r_state)
                S_FETCH: begin
                    if (MemReady) r_state <= S_DECODE;
                    else if (w_timeout) begin
                        r_memerr <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_DECODE: begin
                    if (!w_condex) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_undef) begin
                        r_state <= S_FETCH;
                    end else begin
                        case (w_op)
                            OP_MEM:  r_state <= S_MEMADR;
                            OP_DP:   r_state <= w_i ? S_EXECI : S_EXECR;
                            OP_BR:   r_state <= S_BRANCH;
                            default: r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR: r_state <= w_s ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD: begin
                    if (MemReady) r_state <= S_MEMWB;
                    else if (w_timeout) begin
                        r_memerr <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_MEMWRITE: begin
                    if (MemReady) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end else if (w_timeout) begin
                        r_memerr <= 1'b1;
                        r_state  <= S_HALT;
                    end
                end
                S_EXECR, S_EXECI: r_state <= S_ALUWB;
                S_ALUWB: begin
                    if (w_s) begin
                        r_flags[3:2] <= ALUFlags[3:2];
                        if (w_arith) r_flags[1:0] <= ALUFlags[1:0];
                    end
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                S_MEMWB, S_BRANCH: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                default: r_state <= S_HALT;
            endcase
        end
    end

    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegSrc     = 2'b00;
        ImmSrc     = IMM_DP;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_RM;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        UndefInstr = 1'b0;
        case (r_state)
            S_FETCH: begin
                MemReq    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                RegSrc     = w_regsrc;
                UndefInstr = w_condex && w_undef;
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_MEM;
                RegSrc  = w_regsrc;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                MemReq = 1'b1;
                RegSrc = w_regsrc;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                RegSrc    = w_regsrc;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                RegSrc   = w_regsrc;
            end
            S_EXECR, S_EXECI, S_ALUWB: begin
                ALUSrcB    = w_i ? SRCB_IMM : SRCB_RM;
                ALUControl = w_alu_ctl;
                RegSrc     = w_regsrc;
                if (r_state == S_ALUWB) begin
                    RegWrite = !w_nowrite && (w_rd != 4'd15);
                    PCWrite  = !w_nowrite && (w_rd == 4'd15);
                end
            end
            S_BRANCH: begin
                ImmSrc    = IMM_BR;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALU;
                PCWrite   = 1'b1;
                RegSrc    = w_regsrc;
            end
            default: ;
        endcase
        // Nothing is committed in a reset cycle, whatever state the access was in.
        if (reset) begin
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign MemErr  = r_memerr;
    assign Retired = r_retired;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Self-checking bench for arm_mc_controller: directed plan plus random instruction stream.
module tb_arm_mc_controller;

    localparam int CNT_W = 6;
`ifdef ARM_MC_CMP_EN
    localparam bit CMP_EN = 1'b1;
`else
    localparam bit CMP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ALUControl, ResultSrc;
    logic        ALUSrcA, UndefInstr, MemErr;
    logic [CNT_W-1:0] Retired;

    arm_mc_controller #(.WAIT_MAX(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .RegSrc(RegSrc), .ImmSrc(ImmSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
        .UndefInstr(UndefInstr), .MemErr(MemErr), .Retired(Retired)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Architectural model: flags and retired count.
    logic mN, mZ, mC, mV;
    logic [CNT_W-1:0] mRet;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond_ok(input logic [3:0] c);
        case (c)
            4'd0:  return mZ;
            4'd1:  return !mZ;
            4'd2:  return mC;
            4'd3:  return !mC;
            4'd4:  return mN;
            4'd5:  return !mN;
            4'd6:  return mV;
            4'd7:  return !mV;
            4'd8:  return mC && !mZ;
            4'd9:  return !mC || mZ;
            4'd10: return mN == mV;
            4'd11: return mN != mV;
            4'd12: return !mZ && (mN == mV);
            4'd13: return mZ || (mN != mV);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        MemReady = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_memreq", MemReq, 1);
        chk("rst_alusrca", ALUSrcA, 1);
        chk("rst_alusrcb", ALUSrcB, 2);
        chk("rst_resultsrc", ResultSrc, 2);
        chk("rst_enables", {MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, UndefInstr}, 0);
        chk("rst_muxes", {RegSrc, ImmSrc, ALUControl}, 0);
        chk("rst_memerr", MemErr, 0);
        chk("rst_retired", Retired, 0);
        tick();
        reset = 1'b0;
        {mN, mZ, mC, mV} = 4'b0000;
        mRet = '0;
    endtask

    // Execute one instruction with fw fetch stalls and nw data-access stalls.
    task automatic run(input logic [31:0] ins, input logic [3:0] fl, input int fw, input int nw);
        logic [3:0] cond, cmd, rd;
        logic [1:0] op, actl;
        logic ib, sb;
        bit ex, legal, undef, nowr, arith;
        byte ph[$];
        cond = ins[31:28]; op = ins[27:26]; ib = ins[25]; cmd = ins[24:21];
        sb = ins[20]; rd = ins[15:12];
        legal = 0; nowr = 0; arith = 0; actl = 2'd0;
        case (cmd)
            4'b0100: begin legal = 1; arith = 1; actl = 2'd0; end
            4'b0010: begin legal = 1; arith = 1; actl = 2'd1; end
            4'b0000: begin legal = 1; actl = 2'd2; end
            4'b1100: begin legal = 1; actl = 2'd3; end
            4'b1010: begin legal = CMP_EN; nowr = 1; arith = 1; actl = 2'd1; end
            4'b1000: begin legal = CMP_EN; nowr = 1; actl = 2'd2; end
            default: ;
        endcase
        ex = cond_ok(cond);
        undef = ex && (op == 2'd3 || (op == 2'd0 && !legal));
        Instr = ins[31:12];
        ALUFlags = fl;
        repeat (fw) ph.push_back("f");
        ph.push_back("F");
        ph.push_back("D");
        if (ex && !undef) begin
            case (op)
                2'd1: begin
                    ph.push_back("A");
                    if (sb) begin
                        repeat (nw) ph.push_back("r");
                        ph.push_back("R");
                        ph.push_back("M");
                    end else begin
                        repeat (nw) ph.push_back("w");
                        ph.push_back("W");
                    end
                end
                2'd0: begin ph.push_back("X"); ph.push_back("U"); end
                default: ph.push_back("B");
            endcase
        end
        foreach (ph[k]) begin
            case (ph[k])
                "f", "r", "w": MemReady = 1'b0;
                "F", "R", "W": MemReady = 1'b1;
                default:       MemReady = 1'($urandom);
            endcase
            @(negedge clk);
            chk("memerr_clear", MemErr, 0);
            chk("undef_pulse", UndefInstr, (ph[k] == "D") ? undef : 1'b0);
            case (ph[k])
                "f": chk("fetch_wait", {MemReq, AdrSrc, IRWrite, PCWrite}, 4'b1000);
                "F": chk("fetch", {MemReq, AdrSrc, IRWrite, PCWrite, ALUSrcA, ALUSrcB}, 7'b1011110);
                "D": chk("decode", {MemReq, IRWrite, PCWrite, RegWrite, MemWrite}, 0);
                "A": chk("memadr", {MemReq, ImmSrc, ALUSrcB, ALUControl}, 7'b0010100);
                "r", "R": chk("memread", {MemReq, AdrSrc, MemWrite, RegWrite}, 4'b1100);
                "M": chk("memwb", {MemReq, RegWrite, ResultSrc}, 4'b0101);
                "w", "W": begin
                    chk("memwrite", {MemReq, AdrSrc, MemWrite, RegWrite}, 4'b1110);
                    chk("str_regsrc", RegSrc, 2'b10);
                end
                "X": chk("exec", {ALUSrcB, ALUControl, RegWrite}, {1'b0, ib, actl, 1'b0});
                "U": chk("aluwb", {RegWrite, PCWrite, ResultSrc},
                         {!nowr && rd != 4'd15, !nowr && rd == 4'd15, 2'b00});
                "B": begin
                    chk("branch", {PCWrite, ImmSrc, ResultSrc, ALUSrcB}, 7'b1101001);
                    chk("br_regsrc", RegSrc, 2'b01);
                end
                default: ;
            endcase
            tick();
        end
        if (!undef) mRet = mRet + 1'b1;
        if (ex && !undef && op == 2'd0 && sb) begin
            {mN, mZ} = fl[3:2];
            if (arith) {mC, mV} = fl[1:0];
        end
        chk("retired", Retired, mRet);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        reset = 1'b1;
        Instr = '0;
        ALUFlags = '0;
        MemReady = 1'b0;
        mRet = '0;
        {mN, mZ, mC, mV} = 4'b0000;
        do_reset();

        run(32'hE0821003, 4'b0000, 0, 0);   // ADD R1,R2,R3
        run(32'hE5912004, 4'b1010, 0, 3);   // LDR, 3 stall cycles
        run(32'hE0521003, 4'b0100, 1, 0);   // SUBS -> Z=1
        run(32'h0A000002, 4'b0000, 0, 0);   // BEQ taken
        run(32'hE0921003, 4'b0000, 0, 0);   // ADDS -> Z=0
        run(32'h0A000002, 4'b0000, 0, 0);   // BEQ not taken
        run(32'hE5812004, 4'b0000, 2, 15);  // STR, one stall short of timeout
        run(32'hE5912004, 4'b0000, 15, 0);  // fetch one stall short of timeout
        run(32'hEC000000, 4'b0000, 0, 0);   // Op=11 undefined
        run(32'hE38FF001, 4'b0000, 0, 0);   // ORR PC,PC,#1
        run(32'hE1510002, 4'b0100, 0, 0);   // CMP R1,R2
        run(32'h0A000002, 4'b0000, 0, 0);   // BEQ depends on CMP legality
        run(32'hE1110002, 4'b1001, 0, 0);   // TST R1,R2
        run(32'h8A000002, 4'b0000, 0, 0);   // BHI
        run(32'hF0821003, 4'b0000, 0, 0);   // NV condition never executes

        for (int n = 0; n < 160; n++)
            run($urandom, 4'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 5)));

        // STR stalled for WAIT_MAX cycles -> MemErr and HALT.
        run(32'hE0821003, 4'b0000, 0, 0);
        Instr = 20'hE5812;
        MemReady = 1'b1;
        @(negedge clk);
        chk("to_fetch", IRWrite, 1);
        tick();
        MemReady = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 16; k++) begin
            MemReady = 1'b0;
            @(negedge clk);
            chk("to_memwrite", {MemReq, MemWrite, MemErr}, 3'b110);
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            MemReady = 1'($urandom);
            @(negedge clk);
            chk("halt_memerr", MemErr, 1);
            chk("halt_outputs", {MemReq, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcA, ResultSrc}, 0);
            chk("halt_retired", Retired, mRet);
            tick();
        end
        do_reset();
        run(32'hE0821003, 4'b0000, 0, 0);

        // Reset in the middle of a stalled store.
        Instr = 20'hE5812;
        MemReady = 1'b1;
        tick();
        MemReady = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("mid_store", {MemReq, MemWrite}, 2'b11);
        do_reset();
        MemReady = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", {MemReq, MemWrite, AdrSrc, IRWrite}, 4'b1000);
        tick();
        run(32'hE5912004, 4'b0000, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
